// File: rtl/tvp5150_cfg_seq_if.sv
// Command bus between the configuration sequencer and a byte-level I2C write master.
// The sequencer is the sole master-side client; the I2C engine sits on the slave modport.
interface tvp5150_cfg_seq_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_dev;
    logic [7:0] m_reg;
    logic [7:0] m_data;
    logic       m_done;
    logic       m_nack;

    modport master (
        output m_valid,
        output m_dev,
        output m_reg,
        output m_data,
        input  m_ready,
        input  m_done,
        input  m_nack
    );

    modport slave (
        input  m_valid,
        input  m_dev,
        input  m_reg,
        input  m_data,
        output m_ready,
        output m_done,
        output m_nack
    );
endinterface

// File: rtl/tvp5150_cfg_seq.sv
// TVP5150 configuration sequencer: power-up delay, table walk with NACK retry,
// then arbitration-free runtime single-register writes through the same I2C master.
module tvp5150_cfg_seq #(
    parameter int unsigned NUM_REGS     = 3,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned PWRUP_CYCLES = 54000,
    parameter int unsigned GAP_CYCLES   = 2700,
    parameter logic [7:0]  DEV_ADDR     = 8'hBA
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic [7:0]               tbl_idx_o,
    input  logic [7:0]               tbl_reg_i,
    input  logic [7:0]               tbl_data_i,
    tvp5150_cfg_seq_if.master        m_bus,
    input  logic                     rt_valid_i,
    output logic                     rt_ready_o,
    input  logic [7:0]               rt_reg_i,
    input  logic [7:0]               rt_data_i,
    output logic                     rt_done_o,
    output logic                     rt_err_o,
    output logic                     init_done_o,
    output logic                     init_err_o,
    output logic                     busy_o
);

    typedef enum logic [3:0] {
        S_PWRUP,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_IDLE,
        S_RT_ISSUE,
        S_RT_WAIT,
        S_RT_GAP
    } state_e;

    localparam logic [19:0] PWRUP_LAST  = 20'(PWRUP_CYCLES - 1);
    localparam logic [19:0] GAP_LAST    = 20'(GAP_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX    = 8'(NUM_REGS - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);
    localparam bit          SKIP_TABLE  = (NUM_REGS == 0);

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  tbl_idx_q, tbl_idx_d;
    logic [3:0]  retry_q, retry_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_reg_q, m_reg_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        init_done_q, init_done_d;
    logic        init_err_q, init_err_d;
    logic        rt_done_q, rt_done_d;
    logic        rt_err_q, rt_err_d;
    logic        busy_q, busy_d;
    logic        accept;

    assign accept = m_valid_q && m_bus.m_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            tbl_idx_q   <= '0;
            retry_q     <= '0;
            m_valid_q   <= 1'b0;
            m_reg_q     <= '0;
            m_data_q    <= '0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            rt_done_q   <= 1'b0;
            rt_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tbl_idx_q   <= tbl_idx_d;
            retry_q     <= retry_d;
            m_valid_q   <= m_valid_d;
            m_reg_q     <= m_reg_d;
            m_data_q    <= m_data_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            rt_done_q   <= rt_done_d;
            rt_err_q    <= rt_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tbl_idx_d   = tbl_idx_q;
        retry_d     = retry_q;
        m_valid_d   = m_valid_q;
        m_reg_d     = m_reg_q;
        m_data_d    = m_data_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        rt_done_d   = 1'b0;
        rt_err_d    = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d = '0;
                    if (SKIP_TABLE) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_LOAD: begin
                m_reg_d   = tbl_reg_i;
                m_data_d  = tbl_data_i;
                m_valid_d = 1'b1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    m_valid_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_bus.m_done) begin
                    if (!m_bus.m_nack) begin
                        retry_d = '0;
                        if (tbl_idx_q == LAST_IDX) begin
                            init_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            tbl_idx_d = tbl_idx_q + 8'd1;
                            state_d   = S_GAP;
                        end
                    end else begin
                        retry_d = retry_q + 4'd1;
                        // On abort tbl_idx stays on the failing entry for diagnosis.
                        if (retry_q + 4'd1 == RETRY_LIMIT) begin
                            init_err_d  = 1'b1;
                            init_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP, S_RT_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_GAP) ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_IDLE: begin
                if (rt_valid_i) begin
                    m_reg_d   = rt_reg_i;
                    m_data_d  = rt_data_i;
                    m_valid_d = 1'b1;
                    state_d   = S_RT_ISSUE;
                end
            end
            S_RT_ISSUE: begin
                if (accept) begin
                    m_valid_d = 1'b0;
                    state_d   = S_RT_WAIT;
                end
            end
            S_RT_WAIT: begin
                if (m_bus.m_done) begin
                    rt_done_d = 1'b1;
                    rt_err_d  = m_bus.m_nack;
                    state_d   = S_RT_GAP;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // busy is registered alongside state so it reads 0 while reset is held.
    always_comb begin
        rt_ready_o = (state_q == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    assign m_bus.m_valid = m_valid_q;
    assign m_bus.m_dev   = DEV_ADDR;
    assign m_bus.m_reg   = m_reg_q;
    assign m_bus.m_data  = m_data_q;
    assign tbl_idx_o     = tbl_idx_q;
    assign rt_done_o     = rt_done_q;
    assign rt_err_o      = rt_err_q;
    assign init_done_o   = init_done_q;
    assign init_err_o    = init_err_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_tvp5150_cfg_seq.sv
// Bench for tvp5150_cfg_seq: scripted I2C master, vector table, randomized runs
// against an entry/attempt-level reference model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_tvp5150_cfg_seq;

    localparam int NUM_REGS = 3;
    localparam int MAX_RETRY = 3;
    localparam int PWRUP = 20;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tbl_idx, tbl_reg, tbl_data;
    logic       rt_valid = 1'b0;
    logic       rt_ready;
    logic [7:0] rt_reg = '0, rt_data = '0;
    logic       rt_done, rt_err, init_done, init_err, busy;

    tvp5150_cfg_seq_if bus();

    tvp5150_cfg_seq #(
        .NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY), .PWRUP_CYCLES(PWRUP),
        .GAP_CYCLES(GAP), .DEV_ADDR(8'hBA)
    ) dut (
        .clk(clk), .resetn(resetn), .tbl_idx_o(tbl_idx), .tbl_reg_i(tbl_reg),
        .tbl_data_i(tbl_data), .m_bus(bus), .rt_valid_i(rt_valid), .rt_ready_o(rt_ready),
        .rt_reg_i(rt_reg), .rt_data_i(rt_data), .rt_done_o(rt_done), .rt_err_o(rt_err),
        .init_done_o(init_done), .init_err_o(init_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] entryOf(input int e);
        case (e)
            0: return 16'h0000;
            1: return 16'h0200;
            2: return 16'h030D;
            default: return 16'hFFFF;
        endcase
    endfunction

    always_comb {tbl_reg, tbl_data} = entryOf(int'(tbl_idx));

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scripted I2C master state
    logic [63:0] nackMask = '0;
    int  holdLow = 0;
    int  latency = 3;
    bit  spurious = 0;
    int  txn = 0;
    int  lowLeft = 0;
    int  doneCnt = 0;
    bit  pendNack = 0;
    bit  outstanding = 0;
    int  lastDoneEdge = 0;
    bit  validPrev = 0;
    bit  firstRisePending = 0;
    int  relCyc = 0;
    int  overlapCnt = 0;
    logic [23:0] cmdQ[$];

    function automatic int pickHold();
        return (holdLow >= 0) ? holdLow : int'($urandom_range(0, 3));
    endfunction

    function automatic int pickLat();
        return (latency > 0) ? latency : int'($urandom_range(1, 5));
    endfunction

    initial begin : bfm
        bus.m_ready = 1'b0;
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            bus.m_nack = 1'b0;
            if (!resetn) begin
                bus.m_ready = 1'b0;
                outstanding = 0;
                doneCnt = 0;
                validPrev = 0;
                lowLeft = pickHold();
            end else begin
                if (outstanding) begin
                    if (bus.m_valid) overlapCnt++;
                    doneCnt--;
                    if (doneCnt <= 0) begin
                        bus.m_done = 1'b1;
                        bus.m_nack = pendNack;
                        outstanding = 0;
                        lastDoneEdge = cyc + 1;
                    end
                end else if (spurious && $urandom_range(0, 7) == 0) begin
                    bus.m_done = 1'b1;
                    bus.m_nack = 1'($urandom_range(0, 1));
                end
                if (bus.m_valid && !validPrev) begin
                    if (firstRisePending) begin
                        checkOutput("pwrupDelay", cyc - relCyc, PWRUP + 1);
                        firstRisePending = 0;
                    end else if (!init_done) begin
                        checkOutput("gapDelay", cyc - lastDoneEdge, GAP + 1);
                    end
                end
                validPrev = bus.m_valid;
                if (bus.m_valid && !outstanding) begin
                    if (lowLeft > 0) begin
                        bus.m_ready = 1'b0;
                        lowLeft--;
                    end else begin
                        bus.m_ready = 1'b1;
                        cmdQ.push_back({bus.m_dev, bus.m_reg, bus.m_data});
                        pendNack = (txn < 64) ? nackMask[txn] : 1'b0;
                        txn++;
                        outstanding = 1;
                        doneCnt = pickLat();
                        lowLeft = pickHold();
                    end
                end else begin
                    bus.m_ready = (lowLeft == 0) && !outstanding;
                end
            end
        end
    end

    // Reference model: walks entries/attempts directly from the NACK script.
    int expEntries[$];

    task automatic runModel(input logic [63:0] mask, output bit err, output int idx);
        int t = 0;
        expEntries.delete();
        err = 0;
        idx = NUM_REGS - 1;
        for (int e = 0; e < NUM_REGS; e++) begin
            int fails = 0;
            bit acked = 0;
            while (!acked) begin
                expEntries.push_back(e);
                if (mask[t]) begin
                    fails++;
                    if (fails == MAX_RETRY) begin
                        err = 1;
                        idx = e;
                        return;
                    end
                end else begin
                    acked = 1;
                end
                t++;
            end
        end
    endtask

    task automatic doReset();
        resetn = 1'b0;
        rt_valid = 1'b0;
        txn = 0;
        cmdQ.delete();
        overlapCnt = 0;
        outstanding = 0;
        doneCnt = 0;
        repeat (2) tick();
        checkOutput("rstPayload", {bus.m_dev, bus.m_reg, bus.m_data, tbl_idx}, 32'hBA000000);
        checkOutput("rstFlags", {bus.m_valid, rt_ready, rt_done, rt_err, init_done, init_err, busy}, 7'b0);
        resetn = 1'b1;
        relCyc = cyc;
        firstRisePending = 1;
    endtask

    task automatic waitInit(input int limit);
        int n = 0;
        while (!init_done && n < limit) begin
            tick();
            n++;
        end
        checkOutput("initDone", init_done, 1);
    endtask

    typedef struct {
        logic [63:0] nackMask;
        int          holdLow;
        int          latency;
        bit          spurious;
        int          expCmds;
        bit          expErr;
        int          expIdx;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        bit mErr;
        int mIdx;
        int n;
        nackMask = v.nackMask;
        holdLow  = v.holdLow;
        latency  = v.latency;
        spurious = v.spurious;
        doReset();
        waitInit(3000);
        runModel(v.nackMask, mErr, mIdx);
        checkOutput("cmdCount", cmdQ.size(), v.expCmds);
        n = (cmdQ.size() < expEntries.size()) ? cmdQ.size() : expEntries.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("cmd%0d", i), cmdQ[i], {8'hBA, entryOf(expEntries[i])});
        checkOutput("initErr", init_err, v.expErr);
        checkOutput("tblIdx", tbl_idx, v.expIdx);
        checkOutput("idleFlags", {busy, rt_ready}, 2'b01);
        repeat (GAP + 4) tick();
        checkOutput("noExtraCmd", cmdQ.size(), v.expCmds);
        checkOutput("overlap", overlapCnt, 0);
    endtask

    task automatic waitRtDone(input int limit);
        int n = 0;
        while (!rt_done && n < limit) begin
            tick();
            n++;
        end
        checkOutput("rtDoneSeen", rt_done, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t vecs[5];
        vec_t rv;
        bit   flag;
        int   n;
        int   doneCyc;
        logic [7:0] r, d;
        bit   nk;

        vecs[0] = '{64'h0,        0, 3, 1'b0, 3, 1'b0, 2};
        vecs[1] = '{64'b00110,    0, 2, 1'b0, 5, 1'b0, 2};
        vecs[2] = '{64'b111,      1, 4, 1'b0, 3, 1'b1, 0};
        vecs[3] = '{64'b11100,    2, 1, 1'b1, 5, 1'b1, 2};
        vecs[4] = '{64'b011010,  -1, 0, 1'b1, 6, 1'b0, 2};

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.nackMask = {32'h0, $urandom & $urandom};
            rv.holdLow  = -1;
            rv.latency  = 0;
            rv.spurious = 1'b1;
            runModel(rv.nackMask, rv.expErr, rv.expIdx);
            rv.expCmds = expEntries.size();
            applyStimulus(rv);
        end

        // m_ready held low for 50 cycles during ISSUE
        nackMask = '0; holdLow = 50; latency = 2; spurious = 0;
        doReset();
        n = 0;
        while (!bus.m_valid && n < PWRUP + 10) begin tick(); n++; end
        checkOutput("issueSeen", bus.m_valid, 1);
        holdLow = 0;
        r = bus.m_reg; d = bus.m_data;
        flag = 1;
        repeat (49) begin
            tick();
            if (!bus.m_valid || bus.m_reg != r || bus.m_data != d || cmdQ.size() != 0) flag = 0;
        end
        checkOutput("heldStable", flag, 1);
        tick();
        checkOutput("singleAccept", cmdQ.size(), 1);
        tick();
        checkOutput("validDropped", bus.m_valid, 0);
        waitInit(3000);
        checkOutput("cmdCountHold", cmdQ.size(), 3);

        // runtime write requested before init, NACKed
        nackMask = 64'b1000; holdLow = 0; latency = 3; spurious = 0;
        doReset();
        rt_valid = 1'b1; rt_reg = 8'h09; rt_data = 8'h80;
        flag = 0; n = 0;
        while (!init_done && n < 3000) begin
            tick();
            n++;
            if (!init_done && rt_ready) flag = 1;
        end
        checkOutput("rtReadyEarly", flag, 0);
        checkOutput("rtReadyIdle", {init_done, rt_ready, busy}, 3'b110);
        tick();
        checkOutput("rtAccepted", {rt_ready, busy, bus.m_valid}, 3'b011);
        rt_valid = 1'b0;
        waitRtDone(100);
        checkOutput("rtErr", rt_err, 1);
        checkOutput("rtDoneLatency", cyc - lastDoneEdge, 0);
        checkOutput("rtCmdCount", cmdQ.size(), 4);
        if (cmdQ.size() >= 4) checkOutput("rtCmd", cmdQ[3], 24'hBA0980);
        doneCyc = cyc;
        tick();
        checkOutput("rtDonePulse", {rt_done, rt_ready}, 2'b00);
        n = 0;
        while (!rt_ready && n < 100) begin tick(); n++; end
        checkOutput("rtGapLen", cyc - doneCyc, GAP);

        // random runtime writes
        holdLow = -1; latency = 0; spurious = 1;
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom); d = 8'($urandom); nk = 1'($urandom_range(0, 1));
            nackMask[txn] = nk;
            n = 0;
            while (!rt_ready && n < 100) begin tick(); n++; end
            rt_valid = 1'b1; rt_reg = r; rt_data = d;
            tick();
            rt_valid = 1'b0;
            waitRtDone(100);
            checkOutput("rtErrRand", rt_err, nk);
            checkOutput("rtCmdRand", cmdQ[cmdQ.size() - 1], {8'hBA, r, d});
        end

        // reset during WAIT of entry 1
        nackMask = '0; holdLow = 0; latency = 20; spurious = 0;
        doReset();
        n = 0;
        while (cmdQ.size() < 2 && n < 500) begin tick(); n++; end
        repeat (3) tick();
        checkOutput("preRstIdx", {tbl_idx, bus.m_reg}, 16'h0102);
        resetn = 1'b0;
        #1;
        checkOutput("asyncRstPayload", {bus.m_dev, bus.m_reg, bus.m_data, tbl_idx}, 32'hBA000000);
        checkOutput("asyncRstFlags", {bus.m_valid, rt_ready, rt_done, rt_err, init_done, init_err, busy}, 7'b0);
        latency = 3;
        doReset();
        n = 0;
        while (cmdQ.size() < 1 && n < 200) begin tick(); n++; end
        checkOutput("restartCount", cmdQ.size(), 1);
        if (cmdQ.size() >= 1) checkOutput("restartEntry0", cmdQ[0], 24'hBA0000);
        waitInit(3000);
        checkOutput("restartCmds", cmdQ.size(), 3);

        // reset while m_valid is high drops it asynchronously
        holdLow = 10;
        doReset();
        n = 0;
        while (!bus.m_valid && n < PWRUP + 10) begin tick(); n++; end
        tick();
        checkOutput("validBeforeRst", bus.m_valid, 1);
        resetn = 1'b0;
        #1;
        checkOutput("asyncValidDrop", bus.m_valid, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
